reg_sweep_checker: RTL and testbench
====================================

# reg_sweep_checker

Synthesizable successor to the simulation-only register-check harness. It runs the processor for a programmed number of cycles, then takes over regfile read port A. It sweeps every architectural register against an expected-value memory, counts mismatches and captures the first failure. It sits between the processor's `rs1` output and the regfile's `ctrl_readRegA` input, so a self-check runs on the board without a testbench.

## Interface
- `NUM_REGS`, 32: registers swept, indices 0..NUM_REGS-1.
- `DATA_WIDTH`, 32: register and expected-value width.
- `ADDR_WIDTH`, 5: register index width; must satisfy 2^ADDR_WIDTH >= NUM_REGS.
- `CYCLE_WIDTH`, 16: width of run-length counter.
- Derived `ERR_WIDTH` = $clog2(NUM_REGS+1).

Ports:
- `clock` in 1: single clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a run.
- `num_cycles` in CYCLE_WIDTH: run length, sampled on accepted `start`.
- `cpu_rs1` in ADDR_WIDTH: processor read index A.
- `rs1_out` out ADDR_WIDTH: index to regfile `ctrl_readRegA`.
- `reg_data` in DATA_WIDTH: regfile `data_readRegA` (combinational read).
- `exp_addr` out ADDR_WIDTH: expected-memory address.
- `exp_data` in DATA_WIDTH: expected-memory data, valid one cycle after `exp_addr`.
- `test_mode` out 1: high while the sweep owns port A.
- `cpu_stall` out 1: high in SWEEP/DRAIN/DONE; processor must not retire.
- `busy` out 1, `done` out 1: status.
- `errors` out ERR_WIDTH: mismatch count.
- `fail_valid` out 1, `fail_reg` out ADDR_WIDTH, `fail_got` out DATA_WIDTH, `fail_exp` out DATA_WIDTH: first mismatch.

## Operation
- States: IDLE, RUN, SWEEP, DRAIN, DONE.
- IDLE: `start` latches `num_cycles` into `cyc_cnt` and clears `errors` and all `fail_*`. It moves to RUN, or straight to SWEEP if `num_cycles`=0.
- RUN: `cyc_cnt` decrements each cycle. At `cyc_cnt`=1 the state goes to SWEEP with `idx`=0.
- SWEEP: `rs1_out`=`exp_addr`=`idx` (registered). `reg_data` is captured into `got_q` and `idx` into `idx_q`; `idx` increments. After `idx`=NUM_REGS-1 the state goes to DRAIN.
- Compare stage, the cycle after each capture: it checks `got_q` against `exp_data` as a 4-state-exact equality. A mismatch increments `errors`. The first mismatch sets `fail_valid` and loads `fail_reg`/`fail_got`/`fail_exp`; later mismatches leave them unchanged.
- DRAIN: performs the final compare, then goes to DONE.
- DONE: `done`=1; outputs hold. A `start` in DONE behaves as in IDLE.
- `rs1_out` = `cpu_rs1` combinationally whenever `test_mode`=0.
- `start` in RUN/SWEEP/DRAIN is ignored.
- `errors` cannot overflow, since ERR_WIDTH covers NUM_REGS.

## Timing
- Reset values: state IDLE, `test_mode` 0, `cpu_stall` 0, `busy` 0, `done` 0, `errors` 0, `fail_*` 0, `exp_addr` 0, `rs1_out`=`cpu_rs1`.
- `busy` is high from the cycle after accepted `start` through DRAIN.
- Total latency from `start` to `done` rising: `num_cycles` + NUM_REGS + 1 cycles. For `num_cycles`=0 it is NUM_REGS + 1.
- `test_mode` and `cpu_stall` rise on the first SWEEP cycle and stay high through DONE. `test_mode` falls on the next accepted `start`.
- `errors` and `fail_*` are final on the first cycle `done`=1.
- Reset asserted mid-operation returns all state to reset values asynchronously. The partial count is discarded.

## Configuration
- `REG_SWEEP_SKIP_ZERO_EN`: when defined, index 0 is issued but never compared. It cannot count as an error or set `fail_*`, so a hardwired-zero x0 with a stale expected file cannot fail.
- When undefined, index 0 is compared like any other register.

## Test plan
- `num_cycles`=10, all regs match -> `done` at cycle 43, `errors`=0, `fail_valid`=0.
- Reg 7 reads 0x5 vs expected 0x6, reg 20 also mismatched -> `errors`=2, `fail_reg`=7, `fail_got`=0x5, `fail_exp`=0x6.
- `num_cycles`=0 -> SWEEP on the first cycle after `start`, `done` after 33 cycles. Second `start` during SWEEP is ignored.
- Reg 0 expected 0x1, actual 0 -> `errors`=1 without the macro; `errors`=0 with `REG_SWEEP_SKIP_ZERO_EN`.
- Reset driven low mid-SWEEP at `idx`=12 -> `test_mode`, `busy`, `errors` return to 0 immediately, and `rs1_out` follows `cpu_rs1`.
- Restart from DONE with fresh data -> `errors` and `fail_*` are cleared before the new run.

Source files
------------

// File: rtl/reg_sweep_checker.sv
// On-board register self-check: runs the CPU for num_cycles, then sweeps regfile port A against an
// expected-value memory. Optional macro REG_SWEEP_SKIP_ZERO_EN excludes index 0 from comparison.
module reg_sweep_checker #(
  parameter int NUM_REGS    = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int CYCLE_WIDTH = 16,
  localparam int ERR_WIDTH  = $clog2(NUM_REGS + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CYCLE_WIDTH-1:0] num_cycles,
  input  logic [ADDR_WIDTH-1:0]  cpu_rs1,
  output logic [ADDR_WIDTH-1:0]  rs1_out,
  input  logic [DATA_WIDTH-1:0]  reg_data,
  output logic [ADDR_WIDTH-1:0]  exp_addr,
  input  logic [DATA_WIDTH-1:0]  exp_data,
  output logic                   test_mode,
  output logic                   cpu_stall,
  output logic                   busy,
  output logic                   done,
  output logic [ERR_WIDTH-1:0]   errors,
  output logic                   fail_valid,
  output logic [ADDR_WIDTH-1:0]  fail_reg,
  output logic [DATA_WIDTH-1:0]  fail_got,
  output logic [DATA_WIDTH-1:0]  fail_exp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  state_t                  state_q, state_d;
  logic [CYCLE_WIDTH-1:0]  cyc_cnt_q, cyc_cnt_d;
  logic [ADDR_WIDTH-1:0]   sweep_idx_q, sweep_idx_d;
  logic                    cmp_vld_q, cmp_vld_d;
  logic [ERR_WIDTH-1:0]    errors_q, errors_d;
  logic                    fail_valid_q, fail_valid_d;
  logic [ADDR_WIDTH-1:0]   fail_reg_q, fail_reg_d;
  logic [DATA_WIDTH-1:0]   fail_got_q, fail_got_d;
  logic [DATA_WIDTH-1:0]   fail_exp_q, fail_exp_d;

  // Capture stage: pure datapath, aligned with the one-cycle expected-memory read latency.
  logic [DATA_WIDTH-1:0]   got_q;
  logic [ADDR_WIDTH-1:0]   idx_q;

  logic cmp_en;
  logic mismatch;

`ifdef REG_SWEEP_SKIP_ZERO_EN
  assign cmp_en = cmp_vld_q && (idx_q != '0);
`else
  assign cmp_en = cmp_vld_q;
`endif

  assign mismatch = cmp_en && (got_q !== exp_data);

  always_ff @(posedge clock) begin
    got_q <= reg_data;
    idx_q <= sweep_idx_q;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cyc_cnt_q    <= '0;
      sweep_idx_q  <= '0;
      cmp_vld_q    <= 1'b0;
      errors_q     <= '0;
      fail_valid_q <= 1'b0;
      fail_reg_q   <= '0;
      fail_got_q   <= '0;
      fail_exp_q   <= '0;
    end else begin
      state_q      <= state_d;
      cyc_cnt_q    <= cyc_cnt_d;
      sweep_idx_q  <= sweep_idx_d;
      cmp_vld_q    <= cmp_vld_d;
      errors_q     <= errors_d;
      fail_valid_q <= fail_valid_d;
      fail_reg_q   <= fail_reg_d;
      fail_got_q   <= fail_got_d;
      fail_exp_q   <= fail_exp_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cyc_cnt_d    = cyc_cnt_q;
    sweep_idx_d  = sweep_idx_q;
    cmp_vld_d    = 1'b0;
    errors_d     = errors_q;
    fail_valid_d = fail_valid_q;
    fail_reg_d   = fail_reg_q;
    fail_got_d   = fail_got_q;
    fail_exp_d   = fail_exp_q;

    // Compare stage never coincides with an accepted start, so the clear below cannot race it.
    if (mismatch) begin
      errors_d = errors_q + ERR_WIDTH'(1);
      if (!fail_valid_q) begin
        fail_valid_d = 1'b1;
        fail_reg_d   = idx_q;
        fail_got_d   = got_q;
        fail_exp_d   = exp_data;
      end
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cyc_cnt_d    = num_cycles;
          sweep_idx_d  = '0;
          errors_d     = '0;
          fail_valid_d = 1'b0;
          fail_reg_d   = '0;
          fail_got_d   = '0;
          fail_exp_d   = '0;
          state_d      = (num_cycles == '0) ? S_SWEEP : S_RUN;
        end
      end
      S_RUN: begin
        cyc_cnt_d = cyc_cnt_q - CYCLE_WIDTH'(1);
        if (cyc_cnt_q == CYCLE_WIDTH'(1)) begin
          sweep_idx_d = '0;
          state_d     = S_SWEEP;
        end
      end
      S_SWEEP: begin
        cmp_vld_d = 1'b1;
        if (sweep_idx_q == LAST_IDX) begin
          state_d = S_DRAIN;
        end else begin
          sweep_idx_d = sweep_idx_q + ADDR_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign test_mode  = (state_q == S_SWEEP) || (state_q == S_DRAIN) || (state_q == S_DONE);
  assign cpu_stall  = test_mode;
  assign busy       = (state_q == S_RUN) || (state_q == S_SWEEP) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign rs1_out    = test_mode ? sweep_idx_q : cpu_rs1;
  assign exp_addr   = sweep_idx_q;
  assign errors     = errors_q;
  assign fail_valid = fail_valid_q;
  assign fail_reg   = fail_reg_q;
  assign fail_got   = fail_got_q;
  assign fail_exp   = fail_exp_q;

endmodule

// File: tb/tb_reg_sweep_checker.sv
// Self-checking bench for reg_sweep_checker: vector table, hand-written corner sequences and random runs.
module tb_reg_sweep_checker;
  localparam int NR = 32;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;
  localparam int EW = $clog2(NR + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_cycles = '0;
  logic [AW-1:0] cpu_rs1 = '0;
  logic [AW-1:0] rs1_out;
  logic [DW-1:0] reg_data;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic          test_mode, cpu_stall, busy, done, fail_valid;
  logic [EW-1:0] errors;
  logic [AW-1:0] fail_reg;
  logic [DW-1:0] fail_got, fail_exp;

  logic [DW-1:0] rf [NR];
  logic [DW-1:0] em [NR];

  int checks = 0;
  int failures = 0;

  reg_sweep_checker dut (
    .clock(clock), .reset(reset), .start(start), .num_cycles(num_cycles),
    .cpu_rs1(cpu_rs1), .rs1_out(rs1_out), .reg_data(reg_data),
    .exp_addr(exp_addr), .exp_data(exp_data), .test_mode(test_mode),
    .cpu_stall(cpu_stall), .busy(busy), .done(done), .errors(errors),
    .fail_valid(fail_valid), .fail_reg(fail_reg), .fail_got(fail_got), .fail_exp(fail_exp)
  );

  always #5 clock = ~clock;

  // Regfile: combinational read. Expected memory: synchronous read.
  assign reg_data = rf[rs1_out];
  always @(posedge clock) exp_data <= em[exp_addr];

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
    end
  endfunction

  function automatic void fill_data(input logic [31:0] mask);
    for (int i = 0; i < NR; i++) begin
      rf[i] = $urandom;
      em[i] = mask[i] ? (rf[i] ^ (32'h1 << $urandom_range(31, 0))) : rf[i];
    end
  endfunction

  // Reference: count every differing register in index order; the first is the reported failure.
  function automatic void model(output int err, output int first);
    err = 0;
    first = -1;
    for (int i = 0; i < NR; i++) begin
`ifdef REG_SWEEP_SKIP_ZERO_EN
      if (i == 0) continue;
`endif
      if (rf[i] !== em[i]) begin
        err++;
        if (first < 0) first = i;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Starts a run from a post-edge sample point and follows it to done, checking the per-cycle trace.
  task automatic run(input int n, input string tag, input int restart_at);
    int  cnt;
    int  bad;
    bit  tm;
    bad = 0;
    num_cycles = CW'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    cnt = 0;
    chk({tag, "_cleared"}, {63'd0, (errors == '0) && !fail_valid && (fail_reg == '0) &&
                                    (fail_got == '0) && (fail_exp == '0)}, 64'd1);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    while (!done && cnt < n + 200) begin
      tm = (cnt >= n);
      if (test_mode !== tm || cpu_stall !== tm || busy !== 1'b1) bad++;
      if (!tm && rs1_out !== cpu_rs1) bad++;
      if (tm && (cnt - n) < NR && (rs1_out !== AW'(cnt - n) || exp_addr !== AW'(cnt - n))) bad++;
      if (cnt == restart_at) begin
        start = 1'b1;
        num_cycles = CW'(7);
      end
      cpu_rs1 = AW'($urandom);
      tick();
      start = 1'b0;
      cnt++;
    end
    chk({tag, "_latency"}, 64'(cnt), 64'(n + NR + 1));
    chk({tag, "_trace"}, 64'(bad), 64'd0);
    chk({tag, "_done_flags"}, {61'd0, busy, test_mode, cpu_stall}, 64'b011);
  endtask

  task automatic check_result(input string tag, input int err, input int first);
    chk({tag, "_errors"}, 64'(errors), 64'(err));
    chk({tag, "_fail_valid"}, {63'd0, fail_valid}, {63'd0, first >= 0});
    chk({tag, "_fail_reg"}, 64'(fail_reg), (first >= 0) ? 64'(first) : 64'd0);
    chk({tag, "_fail_got"}, 64'(fail_got), (first >= 0) ? 64'(rf[first]) : 64'd0);
    chk({tag, "_fail_exp"}, 64'(fail_exp), (first >= 0) ? 64'(em[first]) : 64'd0);
  endtask

  typedef struct {
    int          n;
    logic [31:0] mask;
    int          kind;       // 0 plain, 1 reg7 = 5 vs 6, 2 reg0 = 0 vs 1
    int          restart_at;
    int          exp_err;
    int          exp_freg;   // -1 when no failure expected
  } vec_t;

  vec_t tbl[6];

  initial begin
    int err, first;
    string tag;

    tbl[0] = '{10, 32'h0, 0, -1, 0, -1};
    tbl[1] = '{5, (32'h1 << 7) | (32'h1 << 20), 1, -1, 2, 7};
    tbl[2] = '{0, 32'h0, 0, 5, 0, -1};
`ifdef REG_SWEEP_SKIP_ZERO_EN
    tbl[3] = '{3, 32'h0, 2, -1, 0, -1};
    tbl[5] = '{2, 32'hFFFF_FFFF, 0, -1, 31, 1};
`else
    tbl[3] = '{3, 32'h0, 2, -1, 1, 0};
    tbl[5] = '{2, 32'hFFFF_FFFF, 0, -1, 32, 0};
`endif
    tbl[4] = '{1, (32'h1 << 31) | (32'h1 << 1), 0, -1, 2, 1};

    fill_data(32'h0);
    cpu_rs1 = 5'd19;
    repeat (3) tick();
    chk("reset_flags", {59'd0, test_mode, cpu_stall, busy, done, fail_valid}, 64'd0);
    chk("reset_errors", 64'(errors), 64'd0);
    chk("reset_fail_data", {fail_got, fail_exp}, 64'd0);
    chk("reset_fail_reg_exp_addr", {54'd0, fail_reg, exp_addr}, 64'd0);
    chk("reset_rs1_passthru", 64'(rs1_out), 64'd19);
    reset = 1'b1;
    tick();

    // Consecutive runs also exercise restart from DONE clearing the previous results.
    for (int v = 0; v < 6; v++) begin
      tag = $sformatf("vec%0d", v);
      fill_data(tbl[v].mask);
      if (tbl[v].kind == 1) begin
        rf[7] = 32'h5;
        em[7] = 32'h6;
      end else if (tbl[v].kind == 2) begin
        rf[0] = 32'h0;
        em[0] = 32'h1;
      end
      run(tbl[v].n, tag, tbl[v].restart_at);
      chk({tag, "_tbl_errors"}, 64'(errors), 64'(tbl[v].exp_err));
      chk({tag, "_tbl_fail_reg"}, {63'd0, fail_valid} << 8 | 64'(fail_reg),
          (tbl[v].exp_freg >= 0) ? (64'd1 << 8 | 64'(tbl[v].exp_freg)) : 64'd0);
      if (tbl[v].kind == 1) begin
        chk({tag, "_fail_got_const"}, 64'(fail_got), 64'h5);
        chk({tag, "_fail_exp_const"}, 64'(fail_exp), 64'h6);
      end
      model(err, first);
      check_result(tag, err, first);
    end

    // Asynchronous reset in the middle of the sweep, at index 12 with two errors already counted.
    fill_data((32'h1 << 2) | (32'h1 << 5));
    num_cycles = CW'(4);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4 + 12) tick();
    chk("midrst_idx", 64'(exp_addr), 64'd12);
    chk("midrst_pre_errors", 64'(errors), 64'd2);
    cpu_rs1 = 5'd9;
    reset = 1'b0;
    #1;
    chk("midrst_flags", {60'd0, test_mode, cpu_stall, busy, fail_valid}, 64'd0);
    chk("midrst_errors", 64'(errors), 64'd0);
    chk("midrst_rs1", 64'(rs1_out), 64'd9);
    tick();
    reset = 1'b1;
    tick();
    chk("postrst_idle", {62'd0, busy, done}, 64'd0);

    // Random runs against the reference model.
    for (int r = 0; r < 8; r++) begin
      tag = $sformatf("rnd%0d", r);
      fill_data(($urandom_range(1, 0) != 0) ? $urandom : 32'h0);
      run($urandom_range(20, 0), tag, -1);
      model(err, first);
      check_result(tag, err, first);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
